// File: rtl/uart_tx_framer.sv
// uart_tx_framer: byte-serial UART transmitter (LSB first, 8N1) with a small input FIFO.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1). Revision 1.0.
`default_nettype none

module uart_tx_framer #(
  parameter logic [15:0] CLKS_PER_BIT    = 16'd1042,
  parameter int          FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [7:0]                 i_tx_data,
  input  logic                       i_tx_valid,
  output logic                       o_tx_ready,
  output logic                       o_txd,
  output logic                       o_tx_busy,
  output logic [FIFO_DEPTH_LOG2:0]   o_fifo_count
);

  localparam int                     c_DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] c_FULL = (FIFO_DEPTH_LOG2+1)'(c_DEPTH);
  localparam logic [15:0]            c_RELOAD = CLKS_PER_BIT - 16'd1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  logic [7:0]                 r_mem [c_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;

  state_t      r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_txd;

  state_t      w_state_nxt;
  logic [15:0] w_timer_nxt;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_txd_nxt;
  logic        w_pop;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  logic        w_timer_zero;
  logic [7:0]  w_head;

`ifdef UART_TX_PARITY_EN
  logic        r_parity;
  logic        w_parity_nxt;
`endif

  assign w_full       = (r_count == c_FULL);
  assign w_empty      = (r_count == '0);
  assign w_push       = i_tx_valid & ~w_full;
  assign w_timer_zero = (r_timer == 16'd0);
  assign w_head       = r_mem[r_rd_ptr];

  assign o_tx_ready   = ~w_full;
  assign o_txd        = r_txd;
  assign o_tx_busy    = (r_state != S_IDLE) | ~w_empty;
  assign o_fifo_count = r_count;

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_tx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_timer  <= 16'd0;
      r_idx    <= 3'd0;
      r_shift  <= 8'd0;
      r_txd    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_txd    <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif

    // Every non-idle bit lasts exactly CLKS_PER_BIT cycles.
    if (r_state != S_IDLE) begin
      w_timer_nxt = w_timer_zero ? c_RELOAD : (r_timer - 16'd1);
    end

    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_timer_nxt = c_RELOAD;
          w_shift_nxt = w_head;
          w_txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt = ^w_head;
`endif
        end
      end
      S_START: begin
        if (w_timer_zero) begin
          w_state_nxt = S_DATA;
          w_txd_nxt   = r_shift[0];
          w_idx_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_timer_zero) begin
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_txd_nxt   = r_parity;
`else
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_idx_nxt   = r_idx + 3'd1;
            w_txd_nxt   = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_timer_zero) begin
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_timer_zero) begin
          // Chain straight into the next start bit when more data is queued.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_shift_nxt = w_head;
            w_txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_parity_nxt = ^w_head;
`endif
          end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed and randomized checks of uart_tx_framer against a
// frame-level model (byte queue plus current frame bit vector and position).
`default_nettype none

module tb_uart_tx_framer;

  localparam logic [15:0] CPB   = 16'd4;
  localparam int          LOG2  = 2;
  localparam int          DEPTH = 1 << LOG2;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
`else
  localparam int          NBITS = 10;
`endif
  localparam int          FLEN  = NBITS * int'(CPB);

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      data;
  logic            valid;
  logic            ready;
  logic            txd;
  logic            busy;
  logic [LOG2:0]   cnt;

  always #5 clk = ~clk;

  uart_tx_framer #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (LOG2)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_tx_data    (data),
    .i_tx_valid   (valid),
    .o_tx_ready   (ready),
    .o_txd        (txd),
    .o_tx_busy    (busy),
    .o_fifo_count (cnt)
  );

  int               n_cmp = 0;
  int               n_err = 0;
  logic [7:0]       q[$];
  bit               m_active = 1'b0;
  int               m_pos = 0;
  logic [NBITS-1:0] m_bits = '0;
  bit               m_accepted = 1'b0;
  int               peak = 0;

  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    logic       v_push;
    logic [7:0] v_d;
    logic       v_rst;
    int         pre;
    logic       e_txd;
    v_push = valid;
    v_d    = data;
    v_rst  = rst;
    pre    = q.size();
    @(posedge clk);
    m_accepted = 1'b0;
    if (v_rst) begin
      q.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      if (m_active) begin
        m_pos++;
        if (m_pos == FLEN) m_active = 1'b0;
      end
      if (!m_active && pre > 0) begin
        m_bits   = frame_of(q.pop_front());
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (v_push && pre < DEPTH) begin
        q.push_back(v_d);
        m_accepted = 1'b1;
      end
    end
    #1;
    e_txd = m_active ? m_bits[m_pos / int'(CPB)] : 1'b1;
    chk("txd",   {31'd0, txd},   {31'd0, e_txd});
    chk("ready", {31'd0, ready}, {31'd0, (q.size() < DEPTH)});
    chk("count", 32'(cnt),       32'(q.size()));
    chk("busy",  {31'd0, busy},  {31'd0, (m_active || q.size() != 0)});
    if (q.size() > peak) peak = q.size();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;

    // Reset and idle
    run(3);
    rst = 1'b0;
    run(20);
    chk("idle_txd",   {31'd0, txd},   32'd1);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_busy",  {31'd0, busy},  32'd0);
    chk("idle_count", 32'(cnt),       32'd0);

    // Single byte 0xA5: start bit appears one cycle after the push
    valid = 1'b1; data = 8'hA5;
    tick();
    valid = 1'b0;
    chk("a5_before_start", {31'd0, txd}, 32'd1);
    tick();
    chk("a5_start", {31'd0, txd}, 32'd0);
    run(FLEN + 5);
    chk("a5_done_busy", {31'd0, busy}, 32'd0);

    // Back-to-back 0x00, 0xFF, 0x55
    peak = 0;
    valid = 1'b1; data = 8'h00; tick();
    data = 8'hFF; tick();
    data = 8'h55; tick();
    valid = 1'b0;
    run(3 * FLEN + 5);
    chk("b2b_peak", 32'(peak), 32'd2);
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    // Full FIFO: 0x01..0x05 accepted, 0x06 stalls until a slot frees
    valid = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      data = 8'(b);
      tick();
    end
    data = 8'h06;
    chk("full_count", 32'(cnt), 32'd4);
    chk("full_ready", {31'd0, ready}, 32'd0);
    begin
      int k;
      k = 0;
      tick();
      while (!m_accepted && k < 200) begin
        tick();
        k++;
      end
      chk("full_6_accepted", {31'd0, m_accepted}, 32'd1);
    end
    valid = 1'b0;
    run(6 * FLEN);
    chk("full_drained", {31'd0, busy}, 32'd0);

    // Reset during data bit 3 of 0x3C
    valid = 1'b1; data = 8'h3C; tick();
    valid = 1'b0;
    begin
      int k;
      k = 0;
      while (!(m_active && m_pos == 4 * int'(CPB) + 1) && k < 100) begin
        tick();
        k++;
      end
      chk("mid_reached", {31'd0, (m_active && m_pos == 4 * int'(CPB) + 1)}, 32'd1);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_txd",   {31'd0, txd}, 32'd1);
    chk("mid_count", 32'(cnt),     32'd0);
    run(60);
    chk("mid_quiet", {31'd0, busy}, 32'd0);

    // Bit after the last data bit: parity (8E1) or stop (8N1)
    for (int t = 0; t < 2; t++) begin
      logic [7:0] b;
      logic       exp9;
      int         k;
      b = (t == 0) ? 8'h07 : 8'h03;
`ifdef UART_TX_PARITY_EN
      exp9 = (t == 0) ? 1'b1 : 1'b0;
`else
      exp9 = 1'b1;
`endif
      valid = 1'b1; data = b; tick();
      valid = 1'b0;
      k = 0;
      while (!(m_active && m_pos == 9 * int'(CPB) + 1) && k < 100) begin
        tick();
        k++;
      end
      chk("bit9_pos", {31'd0, (m_active && m_pos == 9 * int'(CPB) + 1)}, 32'd1);
      chk("bit9_val", {31'd0, txd}, {31'd0, exp9});
      run(FLEN);
    end

    // Randomized traffic; the producer holds a byte until it is accepted
    begin
      bit holding;
      holding = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (!holding) begin
          valid = ($urandom_range(0, 3) == 0);
          data  = 8'($urandom);
        end
        if (i == 250) rst = 1'b1;
        tick();
        rst = 1'b0;
        holding = valid && !m_accepted;
      end
      valid = 1'b0;
      run(DEPTH * FLEN + FLEN + 10);
      chk("rand_drained", {31'd0, busy}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
